hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core. It drives the write-enables and flush (bubble) controls of the PC, IF/ID, ID/EX and EX/MEM latches.
- Detects three conditions:
  - load-use data hazards between ID and EX;
  - taken branches resolved in MEM;
  - multi-cycle mult/div operations occupying EX.
- Holds or flushes the pipeline for the required number of cycles and keeps saturating stall and flush statistics for debug.

---
 rtl/hazard_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs in, latch controls and debug counters out.
// Latency: none of its own; pure signal grouping.
// Backpressure: none; the pipeline (master) always presents inputs, the controller (slave) answers combinationally.
interface hazard_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [4:0]       ex_rt;
   logic             ex_muldiv;
   logic             mem_branch_taken;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_write;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             busy;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   // Pipeline side: presents hazard sources, consumes latch controls.
   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_muldiv, mem_branch_taken,
      input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush,
             busy, stall_count, flush_count
   );

   // Controller side.
   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_muldiv, mem_branch_taken,
      output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush,
             busy, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, MEM branch flushes, mult/div EX holds, with debug counters.
// Latency: latch controls are combinational from state and inputs; state and counters update on clk.
// Backpressure: stalls the front end by dropping pc_write/if_id_write (and id_ex_write for mult/div).
module hazard_ctrl #(
   parameter int MEM_LATENCY   = 1,
   parameter int MULDIV_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic     clk,
   input  logic     rst,
   hazard_if.slave  hif
);

   typedef enum logic [1:0] {RUN, LD_WAIT, MD_WAIT} state_t;

   // Extra hold cycles after the entry cycle: a load-use stall lasts MEM_LATENCY cycles,
   // a mult/div freeze lasts MULDIV_CYCLES-1 cycles.
   localparam logic [4:0] LD_LOAD = 5'(MEM_LATENCY - 2);
   localparam logic [4:0] MD_LOAD = 5'(MULDIV_CYCLES - 2);

   state_t           state_q, state_d;
   logic [4:0]       wcnt_q, wcnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic load_use;
   logic flush_evt;
   logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, busy;

   // Hazard decode; a dependency on r0 never stalls.
   always_comb begin
      load_use = hif.ex_mem_read && (hif.ex_rt != 5'd0) &&
                 ((hif.ex_rt == hif.id_rs) || (hif.id_uses_rt && (hif.ex_rt == hif.id_rt)));
   end

   // Next-state and latch controls; reset forces every latch to bubble and holds the front end.
   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      flush_evt    = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      busy         = 1'b0;
      case (state_q)
         RUN: begin
            if (hif.mem_branch_taken) begin
               // Squashes everything younger, including any stalling instruction.
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
               flush_evt    = 1'b1;
            end else if (hif.ex_muldiv) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_write  = 1'b0;
               ex_mem_flush = 1'b1;
               if (MULDIV_CYCLES > 2) begin
                  wcnt_d  = MD_LOAD;
                  state_d = MD_WAIT;
               end
            end else if (load_use) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
               if (MEM_LATENCY > 1) begin
                  wcnt_d  = LD_LOAD;
                  state_d = LD_WAIT;
               end
            end
         end
         LD_WAIT: begin
            busy        = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (wcnt_q == 5'd0) state_d = RUN;
            else                wcnt_d  = wcnt_q - 5'd1;
         end
         MD_WAIT: begin
            // The last hold cycle is wcnt==1; the following RUN cycle lets the result into EX/MEM.
            busy         = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            if (wcnt_q <= 5'd1) begin
               state_d = RUN;
               wcnt_d  = 5'd0;
            end else begin
               wcnt_d = wcnt_q - 5'd1;
            end
         end
         default: begin
            state_d = RUN;
            wcnt_d  = 5'd0;
         end
      endcase
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         busy         = 1'b0;
         flush_evt    = 1'b0;
      end
   end

   // Saturating statistics.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write && !rst && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}}))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   // State, wait counter and statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         wcnt_q      <= 5'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Drive the bundle.
   always_comb begin
      hif.pc_write     = pc_write;
      hif.if_id_write  = if_id_write;
      hif.if_id_flush  = if_id_flush;
      hif.id_ex_write  = id_ex_write;
      hif.id_ex_flush  = id_ex_flush;
      hif.ex_mem_flush = ex_mem_flush;
      hif.busy         = busy;
      hif.stall_count  = stall_cnt_q;
      hif.flush_count  = flush_cnt_q;
   end

endmodule
